uart_tx_feeder: RTL

- Byte-queue and launch controller that sits directly upstream of the UART transmitter.
- Buffers bytes written from the bus-side register logic in a DEPTH-entry FIFO.
- Presents one byte at a time on tx_data with a one-cycle tx_start pulse, then waits for the transmitter's done pulse before launching the next byte.
- Runs entirely in the tx_clk domain.

---
 rtl/uart_tx_feeder_if.sv | 41 ++++
 rtl/uart_tx_feeder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between the bus-side register logic / UART transmitter and
// the uart_tx_feeder. The feeder connects through the slave modport.
// The timeout member only exists when UART_TX_FEEDER_TIMEOUT_EN is defined.
interface uart_tx_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              en;
    logic              clr_ovf;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_start;
    logic              tx_enable;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              active;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic              timeout;
`endif

    modport master (
        output wr_en, wr_data, en, clr_ovf, tx_busy, tx_done,
        input  tx_start, tx_enable, tx_data, full, empty, level, overflow, active
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        , input timeout
`endif
    );

    modport slave (
        input  wr_en, wr_data, en, clr_ovf, tx_busy, tx_done,
        output tx_start, tx_enable, tx_data, full, empty, level, overflow, active
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        , output timeout
`endif
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte queue and launch controller in front of the UART transmitter.
// Bytes are buffered in a DEPTH-entry circular FIFO and launched one at a
// time with a single-cycle tx_start; the next launch waits for tx_done plus
// one GAP cycle so the line idles high for at least two cycles between frames.
// Optional: define UART_TX_FEEDER_TIMEOUT_EN to add a WAIT_DONE watchdog and a
// sticky timeout flag.
module uart_tx_feeder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic            tx_clk,
    input  logic            rst_n,
    uart_tx_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W:0]     level_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                ovf_q;
    logic                full, empty, pop, wr_acc, drop, to_fire;

    assign full   = (level_q == FULL_LVL);
    assign empty  = (level_q == '0);
    // Pop only on IDLE->LAUNCH; a fresh write is seen next cycle (no bypass).
    assign pop    = (state_q == IDLE) && bus.en && !empty;
    assign wr_acc = bus.wr_en && (!full || pop);
    assign drop   = bus.wr_en && full && !pop;

    // Storage array, no reset needed: contents are qualified by level.
    always_ff @(posedge tx_clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wr_data;
    end

    // Pointers, occupancy and the launched byte register.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level_q   <= '0;
            tx_data_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tx_data_q <= mem[rd_ptr];
            end
            case ({wr_acc, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n)           ovf_q <= 1'b0;
        else if (drop)        ovf_q <= 1'b1;
        else if (bus.clr_ovf) ovf_q <= 1'b0;
    end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic [4:0] wd_cnt;
    logic       busy_seen;
    logic       to_q;

    // Watchdog fires if busy never shows within 2 cycles of LAUNCH or
    // done never shows within 20 cycles.
    assign to_fire = (state_q == WAIT_DONE) && !bus.tx_done &&
                     ((wd_cnt == 5'd19) ||
                      (wd_cnt == 5'd1 && !busy_seen && !bus.tx_busy));

    // Watchdog counter and busy tracker, running only in WAIT_DONE.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            busy_seen <= 1'b0;
        end else if (state_q != WAIT_DONE) begin
            wd_cnt    <= '0;
            busy_seen <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (bus.tx_busy) busy_seen <= 1'b1;
        end
    end

    // Sticky timeout flag, cleared together with overflow.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n)           to_q <= 1'b0;
        else if (to_fire)     to_q <= 1'b1;
        else if (bus.clr_ovf) to_q <= 1'b0;
    end

    assign bus.timeout = to_q;
`else
    logic unused_busy;
    assign unused_busy = bus.tx_busy;
    assign to_fire     = 1'b0;
`endif

    // State register.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; en only gates new launches, never aborts a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pop) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.tx_done)  state_d = GAP;
                else if (to_fire) state_d = IDLE;
            end
            GAP:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign bus.tx_start  = (state_q == LAUNCH);
    assign bus.active    = (state_q == LAUNCH) || (state_q == WAIT_DONE);
    assign bus.tx_enable = bus.en;
    assign bus.tx_data   = tx_data_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.level     = level_q;
    assign bus.overflow  = ovf_q;
endmodule
